// File: rtl/grad_dac_spi_seq_if.sv
// Avalon-style register bus between a CPU master and the gradient DAC SPI sequencer.
interface grad_dac_spi_seq_if;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu
    );

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu
    );
endinterface

// File: rtl/grad_dac_spi_seq.sv
// SPI master for gradient DACs: CPU-fed TX FIFO, per-word mode latching, and
// a LEAD/SHIFT/TRAIL/GAP framing FSM driving SCLK, MOSI and the slave selects.
module grad_dac_spi_seq #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_SLAVES = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    grad_dac_spi_seq_if.slave     bus,
    output logic                  irq,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [NUM_SLAVES-1:0] SS_n
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_WIDTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_e;
    state_e state_q, state_d;

    logic [6:0]            ctrl_q;
    logic [DIV_WIDTH-1:0]  clkdiv_q, divL_q, divCnt_q;
    logic [NUM_SLAVES-1:0] ssmask_q, ssn_q;
    logic [DATA_WIDTH-1:0] rxData_q, txShift_q, rxShift_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rdPtr_q, wrPtr_q;
    logic [LW-1:0]         level_q;
    logic [EW-1:0]         edgeCnt_q;
    logic [31:0]           dataOut_q, readMux;
    logic rrdy_q, toe_q, roe_q, irq_q, cpolL_q, cphaL_q, sclk_q, mosi_q;

    logic wrEn, rdEn, txWr, statusWr, ctrlWr, divWr, maskWr, rxRd;
    logic fifoEmpty, fifoFull, busy, tmt, pushOk, dropEv;
    logic boundary, lastEdge, oddEdge, shiftNow, sampleNow;
    logic startWord, sclkEdge, wordDone;
    logic [DATA_WIDTH-1:0] head;
    logic unusedBits;

    assign wrEn     = bus.spi_select & ~bus.write_n;
    assign rdEn     = bus.spi_select & ~bus.read_n;
    assign txWr     = wrEn && (bus.mem_addr == 3'd1);
    assign statusWr = wrEn && (bus.mem_addr == 3'd2);
    assign ctrlWr   = wrEn && (bus.mem_addr == 3'd3);
    assign divWr    = wrEn && (bus.mem_addr == 3'd4);
    assign maskWr   = wrEn && (bus.mem_addr == 3'd5);
    assign rxRd     = rdEn && (bus.mem_addr == 3'd0);
    assign unusedBits = ^bus.data_from_cpu;

    assign fifoEmpty = (level_q == '0);
    assign fifoFull  = (level_q == FULL_LEVEL);
    assign busy      = (state_q != IDLE);
    assign tmt       = fifoEmpty & ~busy;
    assign head      = mem_q[rdPtr_q];
    // A push into a full FIFO survives only if the FSM frees a slot the same cycle.
    assign pushOk    = txWr && (!fifoFull || startWord);
    assign dropEv    = txWr && fifoFull && !startWord;

    assign boundary  = (divCnt_q == '0);
    assign lastEdge  = (edgeCnt_q == LAST_EDGE);
    assign oddEdge   = ~edgeCnt_q[0];
    assign shiftNow  = sclkEdge & (cphaL_q ? oddEdge : ~oddEdge);
    assign sampleNow = sclkEdge & (cphaL_q ? ~oddEdge : oddEdge);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifoEmpty) state_d = LEAD;
            LEAD:    if (boundary) state_d = SHIFT;
            SHIFT:   if (boundary && lastEdge) state_d = TRAIL;
            TRAIL:   if (boundary) state_d = GAP;
            GAP:     if (boundary) state_d = fifoEmpty ? IDLE : LEAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        startWord = 1'b0;
        sclkEdge  = 1'b0;
        wordDone  = 1'b0;
        case (state_q)
            IDLE:    startWord = !fifoEmpty;
            LEAD:    sclkEdge  = boundary;
            SHIFT:   sclkEdge  = boundary && !lastEdge;
            TRAIL:   wordDone  = boundary;
            GAP:     startWord = boundary && !fifoEmpty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pushOk) mem_q[wrPtr_q] <= bus.data_from_cpu[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (pushOk)    wrPtr_q <= wrPtr_q + AW'(1);
            if (startWord) rdPtr_q <= rdPtr_q + AW'(1);
            level_q <= level_q + LW'(pushOk) - LW'(startWord);
        end
    end

    // A read racing a completion keeps RRDY and suppresses ROE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            clkdiv_q <= '0;
            ssmask_q <= NUM_SLAVES'(1);
            rxData_q <= '0;
            rrdy_q   <= 1'b0;
            toe_q    <= 1'b0;
            roe_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrlWr) ctrl_q   <= bus.data_from_cpu[6:0];
            if (divWr)  clkdiv_q <= bus.data_from_cpu[DIV_WIDTH-1:0];
            if (maskWr) ssmask_q <= bus.data_from_cpu[NUM_SLAVES-1:0];
            if (wordDone) rxData_q <= rxShift_q;
            rrdy_q <= wordDone | (rrdy_q & ~rxRd);
            roe_q  <= (roe_q & ~statusWr) | (wordDone & rrdy_q & ~rxRd);
            toe_q  <= (toe_q & ~statusWr) | dropEv;
            irq_q  <= (~fifoFull & ctrl_q[2]) | (rrdy_q & ctrl_q[3]) | (toe_q & ctrl_q[4])
                    | (roe_q & ctrl_q[5]) | (tmt & ctrl_q[6]);
        end
    end

    always_comb begin
        readMux = '0;
        case (bus.mem_addr)
            3'd0:    readMux = 32'(rxData_q);
            3'd2:    readMux = {25'd0, busy, tmt, toe_q, roe_q, rrdy_q, ~fifoFull, fifoEmpty};
            3'd3:    readMux = {25'd0, ctrl_q};
            3'd4:    readMux = 32'(clkdiv_q);
            3'd5:    readMux = 32'(ssmask_q);
            3'd6:    readMux = 32'(level_q);
            default: readMux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) dataOut_q <= '0;
        else       dataOut_q <= rdEn ? readMux : '0;
    end

    // Mode, divider and mask are frozen per word so mid-frame CPU writes only affect the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpolL_q   <= 1'b0;
            cphaL_q   <= 1'b0;
            divL_q    <= '0;
            divCnt_q  <= '0;
            edgeCnt_q <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ssn_q     <= '1;
        end else if (startWord) begin
            cpolL_q   <= ctrl_q[0];
            cphaL_q   <= ctrl_q[1];
            divL_q    <= clkdiv_q;
            divCnt_q  <= clkdiv_q;
            edgeCnt_q <= '0;
            rxShift_q <= '0;
            sclk_q    <= ctrl_q[0];
            ssn_q     <= ~ssmask_q;
            txShift_q <= ctrl_q[1] ? head : {head[DATA_WIDTH-2:0], 1'b0};
            mosi_q    <= ctrl_q[1] ? 1'b0 : head[DATA_WIDTH-1];
        end else begin
            divCnt_q <= boundary ? divL_q : divCnt_q - DIV_WIDTH'(1);
            if (state_q == IDLE) sclk_q <= ctrl_q[0];
            if (sclkEdge) begin
                sclk_q    <= ~sclk_q;
                edgeCnt_q <= edgeCnt_q + EW'(1);
            end
            if (shiftNow) begin
                mosi_q    <= txShift_q[DATA_WIDTH-1];
                txShift_q <= {txShift_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (sampleNow) rxShift_q <= {rxShift_q[DATA_WIDTH-2:0], MISO};
            if (wordDone)  ssn_q <= '1;
        end
    end

    assign bus.data_to_cpu = dataOut_q;
    assign irq  = irq_q;
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign SS_n = ssn_q;
endmodule

// File: tb/tb_grad_dac_spi_seq.sv
// Directed bench for grad_dac_spi_seq: MISO is looped back to MOSI so every
// transmitted word comes back as RXDATA.
module tb_grad_dac_spi_seq;
    logic       clk;
    logic       reset;
    logic       irq, SCLK, MOSI, MISO;
    logic [3:0] SS_n;
    int vectors;
    int miscompares;

    grad_dac_spi_seq_if bus();

    grad_dac_spi_seq #(
        .DATA_WIDTH(24), .NUM_SLAVES(4), .FIFO_DEPTH(4), .DIV_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .irq(irq),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
    );

    assign MISO = MOSI;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.spi_select = 1'b1; bus.write_n = 1'b0;
        bus.mem_addr = addr; bus.data_from_cpu = data;
        @(posedge clk); #1;
        bus.spi_select = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic busRead(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.spi_select = 1'b1; bus.read_n = 1'b0; bus.mem_addr = addr;
        @(posedge clk); #1;
        data = bus.data_to_cpu;
        bus.spi_select = 1'b0; bus.read_n = 1'b1;
    endtask

    // Observes one SS_n-low frame, gathering SCLK toggle statistics.
    task automatic watchFrame(input int limit, output int rises, output int falls,
                              output int minTog, output int maxTog, output logic [3:0] ssFrame,
                              output logic firstMosi, output int frameCycles, output bit timedOut);
        int cyc, lastTog;
        logic prevSclk;
        bit first;
        rises = 0; falls = 0; minTog = 1000000; maxTog = 0; frameCycles = 0;
        firstMosi = 1'bx; first = 1'b1; cyc = 0; lastTog = 0;
        @(negedge clk);
        while (SS_n === 4'hF && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        ssFrame = SS_n;
        prevSclk = SCLK;
        while (SS_n !== 4'hF && frameCycles < limit) begin
            @(negedge clk);
            frameCycles++;
            if (SCLK !== prevSclk) begin
                if (SCLK === 1'b1) rises++;
                else falls++;
                if (first) begin
                    firstMosi = MOSI;
                    first = 1'b0;
                end else begin
                    if (frameCycles - lastTog < minTog) minTog = frameCycles - lastTog;
                    if (frameCycles - lastTog > maxTog) maxTog = frameCycles - lastTog;
                end
                lastTog = frameCycles;
                prevSclk = SCLK;
            end
        end
        timedOut = (cyc >= limit) || (frameCycles >= limit);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({SCLK, MOSI, irq, SS_n} !== 7'b0001111) begin
            miscompares++;
            $display("[TB] FAIL reset_pins: got %b expected %b", {SCLK, MOSI, irq, SS_n}, 7'b0001111);
        end
        vectors++;
        if (bus.data_to_cpu !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected %h", bus.data_to_cpu, 32'h0);
        end
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h23) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got %h expected %h", rd, 32'h23);
        end
        busRead(3'd5, rd);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("[TB] FAIL reset_ssmask: got %h expected %h", rd, 32'h1);
        end
        busRead(3'd6, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_level: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_loopback();
        int rises, falls, minTog, maxTog, frameCycles;
        logic [3:0] ssFrame;
        logic firstMosi;
        bit timedOut;
        logic [31:0] rd;
        busWrite(3'd4, 32'd1);
        busWrite(3'd3, 32'h0);
        busWrite(3'd5, 32'h2);
        busWrite(3'd1, 32'h00A5F00F);
        watchFrame(2000, rises, falls, minTog, maxTog, ssFrame, firstMosi, frameCycles, timedOut);
        vectors++;
        if (timedOut || ssFrame !== 4'b1101) begin
            miscompares++;
            $display("[TB] FAIL loop_ssn: got %b (timeout %0d) expected %b", ssFrame, timedOut, 4'b1101);
        end
        vectors++;
        if (rises !== 24 || falls !== 24) begin
            miscompares++;
            $display("[TB] FAIL loop_edges: got %0d/%0d expected 24/24", rises, falls);
        end
        vectors++;
        if (minTog !== 2 || maxTog !== 2) begin
            miscompares++;
            $display("[TB] FAIL loop_halfperiod: got %0d..%0d expected 2..2", minTog, maxTog);
        end
        vectors++;
        if (frameCycles !== 100) begin
            miscompares++;
            $display("[TB] FAIL loop_frame_len: got %0d expected 100", frameCycles);
        end
        repeat (5) @(negedge clk);
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h27) begin
            miscompares++;
            $display("[TB] FAIL loop_status: got %h expected %h", rd, 32'h27);
        end
        busRead(3'd0, rd);
        vectors++;
        if (rd !== 32'h00A5F00F) begin
            miscompares++;
            $display("[TB] FAIL loop_rxdata: got %h expected %h", rd, 32'h00A5F00F);
        end
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h23) begin
            miscompares++;
            $display("[TB] FAIL loop_rrdy_clear: got %h expected %h", rd, 32'h23);
        end
    endtask

    task automatic test_cpol_cpha();
        int rises, falls, minTog, maxTog, frameCycles;
        logic [3:0] ssFrame;
        logic firstMosi;
        bit timedOut;
        logic [31:0] rd;
        busWrite(3'd3, 32'h3);
        busWrite(3'd5, 32'h1);
        repeat (2) @(negedge clk);
        vectors++;
        if (SCLK !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mode3_idle_sclk: got %b expected 1", SCLK);
        end
        busWrite(3'd1, 32'h00800001);
        watchFrame(2000, rises, falls, minTog, maxTog, ssFrame, firstMosi, frameCycles, timedOut);
        vectors++;
        if (timedOut || firstMosi !== 1'b1 || ssFrame !== 4'b1110) begin
            miscompares++;
            $display("[TB] FAIL mode3_first_bit: got mosi %b ss %b (timeout %0d) expected 1 1110",
                     firstMosi, ssFrame, timedOut);
        end
        vectors++;
        if (falls !== 24 || rises !== 24 || frameCycles !== 100) begin
            miscompares++;
            $display("[TB] FAIL mode3_frame: got %0d/%0d len %0d expected 24/24 len 100",
                     falls, rises, frameCycles);
        end
        busRead(3'd0, rd);
        vectors++;
        if (rd !== 32'h00800001 || SCLK !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mode3_rxdata: got %h sclk %b expected %h sclk 1", rd, SCLK, 32'h00800001);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] rd;
        int frames, gaps, gapBad, highRun;
        bit prevLow;
        busWrite(3'd3, 32'h0);
        busWrite(3'd4, 32'd100);
        for (int i = 1; i <= 6; i++) busWrite(3'd1, 32'h00111111 * i);
        busRead(3'd6, rd);
        vectors++;
        if (rd !== 32'd4) begin
            miscompares++;
            $display("[TB] FAIL ovf_level: got %0d expected 4", rd);
        end
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h50) begin
            miscompares++;
            $display("[TB] FAIL ovf_status_busy: got %h expected %h", rd, 32'h50);
        end
        frames = 0; gaps = 0; gapBad = 0; highRun = 0; prevLow = 1'b0;
        for (int i = 0; i < 26500; i++) begin
            @(negedge clk);
            if (SS_n !== 4'hF) begin
                if (!prevLow) begin
                    frames++;
                    if (frames > 1) begin
                        gaps++;
                        if (highRun != 101) gapBad++;
                    end
                end
                prevLow = 1'b1;
                highRun = 0;
            end else begin
                prevLow = 1'b0;
                highRun++;
            end
        end
        vectors++;
        if (frames !== 5) begin
            miscompares++;
            $display("[TB] FAIL ovf_frames: got %0d expected 5", frames);
        end
        vectors++;
        if (gaps !== 4 || gapBad !== 0) begin
            miscompares++;
            $display("[TB] FAIL ovf_gap: got %0d gaps %0d wrong expected 4 gaps 0 wrong", gaps, gapBad);
        end
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h3F) begin
            miscompares++;
            $display("[TB] FAIL ovf_status_end: got %h expected %h", rd, 32'h3F);
        end
        busRead(3'd0, rd);
        vectors++;
        if (rd !== 32'h00555555) begin
            miscompares++;
            $display("[TB] FAIL ovf_rxdata: got %h expected %h", rd, 32'h00555555);
        end
        busWrite(3'd2, 32'h0);
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h23) begin
            miscompares++;
            $display("[TB] FAIL ovf_status_clear: got %h expected %h", rd, 32'h23);
        end
    endtask

    task automatic test_roe_irq();
        logic [31:0] rd;
        int cyc;
        busWrite(3'd4, 32'd0);
        busWrite(3'd3, 32'h20);
        busWrite(3'd1, 32'h000000AA);
        busWrite(3'd1, 32'h00000055);
        cyc = 0;
        while (irq !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL roe_irq_set: got %b expected 1", irq);
        end
        repeat (5) @(negedge clk);
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h2F) begin
            miscompares++;
            $display("[TB] FAIL roe_status: got %h expected %h", rd, 32'h2F);
        end
        busRead(3'd0, rd);
        vectors++;
        if (rd !== 32'h00000055) begin
            miscompares++;
            $display("[TB] FAIL roe_rxdata: got %h expected %h", rd, 32'h00000055);
        end
        busWrite(3'd2, 32'h0);
        @(posedge clk); #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL roe_irq_clear: got %b expected 0", irq);
        end
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h23) begin
            miscompares++;
            $display("[TB] FAIL roe_status_clear: got %h expected %h", rd, 32'h23);
        end
    endtask

    task automatic test_reset_midword();
        logic [31:0] rd;
        logic prevSclk;
        int rises, cyc, toggles, ssHigh;
        busWrite(3'd3, 32'h0);
        busWrite(3'd4, 32'd1);
        busWrite(3'd1, 32'h00ABCDEF);
        busWrite(3'd1, 32'h00123456);
        busWrite(3'd1, 32'h00654321);
        rises = 0; cyc = 0; prevSclk = SCLK;
        while (rises < 10 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (SCLK === 1'b1 && prevSclk === 1'b0) rises++;
            prevSclk = SCLK;
        end
        vectors++;
        if (rises !== 10) begin
            miscompares++;
            $display("[TB] FAIL rst_reach_bit10: got %0d edges expected 10", rises);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (SS_n !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL rst_ssn_release: got %b expected %b", SS_n, 4'hF);
        end
        @(negedge clk);
        reset = 1'b0;
        busRead(3'd6, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL rst_level: got %0d expected 0", rd);
        end
        busRead(3'd2, rd);
        vectors++;
        if (rd !== 32'h23) begin
            miscompares++;
            $display("[TB] FAIL rst_status: got %h expected %h", rd, 32'h23);
        end
        toggles = 0; ssHigh = 0; prevSclk = SCLK;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (SCLK !== prevSclk) toggles++;
            if (SS_n === 4'hF) ssHigh++;
            prevSclk = SCLK;
        end
        vectors++;
        if (toggles !== 0 || ssHigh !== 200) begin
            miscompares++;
            $display("[TB] FAIL rst_quiet: got %0d toggles %0d high expected 0 200", toggles, ssHigh);
        end
    endtask

    task automatic test_back_to_back_clkdiv();
        int rises, falls, minTog, maxTog, frameCycles;
        logic [3:0] ssFrame;
        logic firstMosi;
        bit timedOut;
        logic [31:0] rd;
        busWrite(3'd4, 32'd1);
        busWrite(3'd1, 32'h00123456);
        busWrite(3'd1, 32'h00654321);
        repeat (20) @(negedge clk);
        busWrite(3'd4, 32'd3);
        watchFrame(2000, rises, falls, minTog, maxTog, ssFrame, firstMosi, frameCycles, timedOut);
        vectors++;
        if (timedOut || minTog !== 2 || maxTog !== 2) begin
            miscompares++;
            $display("[TB] FAIL div_current_frame: got %0d..%0d (timeout %0d) expected 2..2",
                     minTog, maxTog, timedOut);
        end
        watchFrame(2000, rises, falls, minTog, maxTog, ssFrame, firstMosi, frameCycles, timedOut);
        vectors++;
        if (timedOut || minTog !== 4 || maxTog !== 4 || rises !== 24) begin
            miscompares++;
            $display("[TB] FAIL div_next_frame: got %0d..%0d rises %0d expected 4..4 rises 24",
                     minTog, maxTog, rises);
        end
        vectors++;
        if (frameCycles !== 200) begin
            miscompares++;
            $display("[TB] FAIL div_next_len: got %0d expected 200", frameCycles);
        end
        repeat (10) @(negedge clk);
        busRead(3'd0, rd);
        vectors++;
        if (rd !== 32'h00654321) begin
            miscompares++;
            $display("[TB] FAIL div_rxdata: got %h expected %h", rd, 32'h00654321);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.spi_select = 1'b0;
        bus.read_n = 1'b1;
        bus.write_n = 1'b1;
        bus.mem_addr = 3'd0;
        bus.data_from_cpu = 32'h0;
        test_reset();
        test_loopback();
        test_cpol_cpha();
        test_fifo_overflow();
        test_roe_irq();
        test_reset_midword();
        test_back_to_back_clkdiv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
